led_pattern_gen: RTL

Parametrised LED pattern generator for the board status LEDs. A prescaler divides `clk_50m` into a step tick, and each step advances an `LED_NUM`-bit pattern in one of four runtime-selectable modes: rotate left, rotate right, bounce, or blink. It sits directly on the LED pins as a drop-in heartbeat/status indicator. It adds run/hold control and a step strobe for other logic.

---
 rtl/led_pkg.sv | 24 ++
 rtl/led_tick_div.sv | 41 ++++
 rtl/led_pattern_gen.sv | 138 +++++++++++++
 3 files changed

// File: rtl/led_pkg.sv
// ============================================================================
// Module      : led_pkg
// Description : Shared types and constants for the LED pattern generator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package led_pkg;

    typedef enum logic [1:0] {
        ROT_L  = 2'd0,
        ROT_R  = 2'd1,
        BOUNCE = 2'd2,
        BLINK  = 2'd3
    } led_mode_e;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

    localparam int PWM_W = 8;

endpackage : led_pkg

`default_nettype wire

// File: rtl/led_tick_div.sv
// ============================================================================
// Module      : led_tick_div
// Description : Step prescaler; pulses tick every TICK_DIV enabled cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_tick_div #(
    parameter int TICK_DIV = 5_000_000
) (
    input  logic clk_50m,
    input  logic reset_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int                c_cnt_w = $clog2(TICK_DIV);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(TICK_DIV - 1);

    logic [c_cnt_w-1:0] r_cnt;
    logic               w_last;

    assign w_last = (r_cnt == c_last);

    always_ff @(posedge clk_50m or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
    end

    // A clear (mode change) always wins over a coincident tick.
    assign tick = en & w_last & ~clr;

endmodule : led_tick_div

`default_nettype wire

// File: rtl/led_pattern_gen.sv
// ============================================================================
// Module      : led_pattern_gen
// Description : Rotate/bounce/blink LED pattern generator with run/hold.
//               Optional PWM dimming when LED_PWM_DIM_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_pattern_gen
    import led_pkg::*;
#(
    parameter int LED_NUM  = 6,
    parameter int TICK_DIV = 5_000_000
) (
    input  logic               clk_50m,
    input  logic               reset_n,
    input  logic               en,
    input  logic [1:0]         mode,
`ifdef LED_PWM_DIM_EN
    input  logic [PWM_W-1:0]   duty,
`endif
    output logic               step,
    output logic [LED_NUM-1:0] led
);

    localparam logic [LED_NUM-1:0] c_lsb = LED_NUM'(1);
    localparam logic [LED_NUM-1:0] c_msb = c_lsb << (LED_NUM - 1);

    led_mode_e          r_mode_q;
    logic [LED_NUM-1:0] r_pat;
    logic               r_dir;
    logic               r_step;
    logic [LED_NUM-1:0] r_led;

    logic               w_mode_chg;
    logic               w_tick;
    logic [LED_NUM-1:0] w_rot_l;
    logic [LED_NUM-1:0] w_rot_r;
    logic [LED_NUM-1:0] w_bnc;
    logic               w_bnc_dir;
    logic [LED_NUM-1:0] w_pat_nxt;
    logic               w_dir_nxt;
    logic [LED_NUM-1:0] w_led_nxt;

    assign w_mode_chg = (led_mode_e'(mode) != r_mode_q);

    led_tick_div #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_div (
        .clk_50m (clk_50m),
        .reset_n (reset_n),
        .en      (en),
        .clr     (w_mode_chg),
        .tick    (w_tick)
    );

    generate
        if (LED_NUM == 1) begin : g_single
            assign w_rot_l   = r_pat;
            assign w_rot_r   = r_pat;
            assign w_bnc     = r_pat;
            assign w_bnc_dir = r_dir;
        end else begin : g_multi
            assign w_rot_l   = {r_pat[LED_NUM-2:0], r_pat[LED_NUM-1]};
            assign w_rot_r   = {r_pat[0], r_pat[LED_NUM-1:1]};
            assign w_bnc     = (r_dir == DIR_UP) ? (r_pat << 1) : (r_pat >> 1);
            // Turn around as soon as the hot bit lands on an end LED.
            assign w_bnc_dir = w_bnc[LED_NUM-1] ? DIR_DN :
                               (w_bnc[0] ? DIR_UP : r_dir);
        end
    endgenerate

    always_comb begin
        w_pat_nxt = r_pat;
        w_dir_nxt = r_dir;
        if (w_mode_chg) begin
            w_pat_nxt = '0;
            w_dir_nxt = DIR_UP;
        end else if (w_tick) begin
            if (r_pat == '0) begin
                w_dir_nxt = DIR_UP;
                case (r_mode_q)
                    ROT_R:   w_pat_nxt = c_msb;
                    BLINK:   w_pat_nxt = '1;
                    default: w_pat_nxt = c_lsb;
                endcase
            end else begin
                case (r_mode_q)
                    ROT_L:   w_pat_nxt = w_rot_l;
                    ROT_R:   w_pat_nxt = w_rot_r;
                    BOUNCE: begin
                        w_pat_nxt = w_bnc;
                        w_dir_nxt = w_bnc_dir;
                    end
                    default: w_pat_nxt = ~r_pat;
                endcase
            end
        end
    end

`ifdef LED_PWM_DIM_EN
    logic [PWM_W-1:0] r_pwm_cnt;

    always_ff @(posedge clk_50m or negedge reset_n) begin
        if (!reset_n) begin
            r_pwm_cnt <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
        end
    end

    assign w_led_nxt = r_pat & {LED_NUM{r_pwm_cnt < duty}};
`else
    assign w_led_nxt = r_pat;
`endif

    always_ff @(posedge clk_50m or negedge reset_n) begin
        if (!reset_n) begin
            r_mode_q <= ROT_L;
            r_pat    <= '0;
            r_dir    <= DIR_UP;
            r_step   <= 1'b0;
            r_led    <= '0;
        end else begin
            r_mode_q <= led_mode_e'(mode);
            r_pat    <= w_pat_nxt;
            r_dir    <= w_dir_nxt;
            r_step   <= w_tick;
            r_led    <= w_led_nxt;
        end
    end

    assign step = r_step;
    assign led  = r_led;

endmodule : led_pattern_gen

`default_nettype wire
